// File: rtl/pi_mem_xfer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pi_mem_xfer_if : Pi request handshake plus RAM bus for pi_mem_xfer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pi_mem_xfer_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] pi_addr;
  logic [DATA_WIDTH-1:0] pi_data_out;
  logic                  pi_rw_b;
  logic                  pi_pending;
  logic                  pi_done;
  logic [DATA_WIDTH-1:0] pi_data_in;
  logic                  slot_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_data_oe;
  logic                  ram_oe_b;
  logic                  ram_we_b;
  logic                  busy;

  modport master (
    output pi_addr, pi_data_out, pi_rw_b, pi_pending, slot_en, ram_data_in,
    input  pi_done, pi_data_in, ram_addr, ram_data_out, ram_data_oe,
           ram_oe_b, ram_we_b, busy
  );

  modport slave (
    input  pi_addr, pi_data_out, pi_rw_b, pi_pending, slot_en, ram_data_in,
    output pi_done, pi_data_in, ram_addr, ram_data_out, ram_data_oe,
           ram_oe_b, ram_we_b, busy
  );
endinterface
`default_nettype wire

// File: rtl/pi_mem_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pi_mem_xfer : runs one Pi byte request as a RAM cycle in a Pi slot   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pi_mem_xfer #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8,
  parameter int RAM_WAIT   = 2
) (
  input  logic           sys_clk,
  input  logic           reset,
  pi_mem_xfer_if.slave   bus
);

  localparam int                CNT_W    = $clog2(RAM_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RAM_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    ACCESS    = 3'd2,
    RECOVER   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_rw_b_q, req_rw_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pi_done_q, pi_done_d;
  logic [DATA_WIDTH-1:0] pi_data_in_q, pi_data_in_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_out_q, ram_data_out_d;
  logic                  ram_data_oe_q, ram_data_oe_d;
  logic                  ram_oe_b_q, ram_oe_b_d;
  logic                  ram_we_b_q, ram_we_b_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      req_rw_b_q     <= 1'b1;
      cnt_q          <= '0;
      pi_done_q      <= 1'b0;
      pi_data_in_q   <= '0;
      ram_addr_q     <= '0;
      ram_data_out_q <= '0;
      ram_data_oe_q  <= 1'b0;
      ram_oe_b_q     <= 1'b1;
      ram_we_b_q     <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      req_rw_b_q     <= req_rw_b_d;
      cnt_q          <= cnt_d;
      pi_done_q      <= pi_done_d;
      pi_data_in_q   <= pi_data_in_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_out_q <= ram_data_out_d;
      ram_data_oe_q  <= ram_data_oe_d;
      ram_oe_b_q     <= ram_oe_b_d;
      ram_we_b_q     <= ram_we_b_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    req_rw_b_d     = req_rw_b_q;
    cnt_d          = cnt_q;
    pi_done_d      = pi_done_q;
    pi_data_in_d   = pi_data_in_q;
    ram_addr_d     = ram_addr_q;
    ram_data_out_d = ram_data_out_q;
    ram_data_oe_d  = ram_data_oe_q;
    ram_oe_b_d     = ram_oe_b_q;
    ram_we_b_d     = ram_we_b_q;

    case (state_q)
      // slot_en is deliberately not looked at here: a coincident slot is lost
      IDLE: begin
        if (bus.pi_pending && !pi_done_q) begin
          req_addr_d = bus.pi_addr;
          req_data_d = bus.pi_data_out;
          req_rw_b_d = bus.pi_rw_b;
          state_d    = WAIT_SLOT;
        end
      end

      WAIT_SLOT: begin
        if (!bus.pi_pending) begin
          state_d = IDLE;
        end else if (bus.slot_en) begin
          state_d    = ACCESS;
          ram_addr_d = req_addr_q;
          cnt_d      = CNT_LOAD;
          if (req_rw_b_q) begin
            ram_oe_b_d = 1'b0;
          end else begin
            ram_we_b_d     = 1'b0;
            ram_data_oe_d  = 1'b1;
            ram_data_out_d = req_data_q;
          end
        end
      end

      // Strobe length is fixed once started; a dropped request still finishes
      ACCESS: begin
        if (cnt_q == '0) begin
          if (req_rw_b_q) begin
            pi_data_in_d = bus.ram_data_in;
          end
          ram_oe_b_d = 1'b1;
          ram_we_b_d = 1'b1;
          state_d    = RECOVER;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      RECOVER: begin
        ram_data_oe_d = 1'b0;
        if (bus.pi_pending) begin
          pi_done_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = IDLE;
        end
      end

      DONE: begin
        if (!bus.pi_pending) begin
          pi_done_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.pi_done      = pi_done_q;
  assign bus.pi_data_in   = pi_data_in_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_data_out = ram_data_out_q;
  assign bus.ram_data_oe  = ram_data_oe_q;
  assign bus.ram_oe_b     = ram_oe_b_q;
  assign bus.ram_we_b     = ram_we_b_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire
